// File: rtl/mnist_neuron_mac_pkg.sv
// Shared fixed-point types for the MNIST neuron datapath: feature/weight words,
// product/sum word, accumulator sizing, FSM encoding and the feature saturator.
package mnist_neuron_mac_pkg;

    localparam int FEATURE_W     = 16;
    localparam int WEIGHT_W      = 16;
    localparam int SUM_W         = FEATURE_W + WEIGHT_W;
    localparam int FEATURE_FRAC  = 8;
    localparam int WEIGHT_FRAC   = 8;
    localparam int ACC_GUARD_DEF = 8;
    localparam int ACC_W         = SUM_W + ACC_GUARD_DEF;

    typedef logic signed [FEATURE_W-1:0] feature_t;
    typedef logic signed [WEIGHT_W-1:0]  weight_t;
    typedef logic signed [SUM_W-1:0]     sum_t;
    typedef logic signed [ACC_W-1:0]     acc_t;

    localparam feature_t FEATURE_MAX = 16'sh7FFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FINISH = 3'd3,
        ST_OUT    = 3'd4
    } neuron_state_e;

    // ReLU plus clamp of a feature-scale sum into a positive feature word.
    function automatic feature_t sat_feature(input sum_t s);
        if (s[SUM_W-1]) begin
            return '0;
        end
        if (|s[SUM_W-2:FEATURE_W-1]) begin
            return FEATURE_MAX;
        end
        return s[FEATURE_W-1:0];
    endfunction

endpackage

// File: rtl/mnist_neuron_mac_relu_sat.sv
// Output stage of the neuron: rescales the Q16.16 accumulator to feature scale,
// adds the bias, saturates to the sum word and applies ReLU into a feature word.
module mnist_relu_sat
    import mnist_neuron_mac_pkg::*;
#(
    parameter int ACC_W_P = ACC_W
) (
    input  logic signed [ACC_W_P-1:0] acc_i,
    input  feature_t                  bias_i,
    output sum_t                      sum_o,
    output feature_t                  feature_o
);

    logic signed [ACC_W_P-1:0] shifted;
    logic signed [ACC_W_P:0]   s_w;
    logic [ACC_W_P-SUM_W+1:0]  top_bits;

    always_comb begin
        // Arithmetic shift floors toward -inf, matching a truncating fixed-point rescale.
        shifted  = acc_i >>> WEIGHT_FRAC;
        s_w      = {shifted[ACC_W_P-1], shifted}
                 + {{(ACC_W_P+1-FEATURE_W){bias_i[FEATURE_W-1]}}, bias_i};
        top_bits = s_w[ACC_W_P:SUM_W-1];
        if ((&top_bits) || !(|top_bits)) begin
            sum_o = s_w[SUM_W-1:0];
        end else if (s_w[ACC_W_P]) begin
            sum_o = {1'b1, {(SUM_W-1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(SUM_W-1){1'b1}}};
        end
        feature_o = sat_feature(sum_o);
    end

endmodule

// File: rtl/mnist_neuron_mac.sv
// Single MNIST neuron: streams feature/weight pairs, accumulates their products
// through a one-cycle product register, then adds bias, ReLU and saturation.
module mnist_neuron_mac
    import mnist_neuron_mac_pkg::*;
#(
    parameter int  MAX_INPUTS = 784,
    parameter int  ACC_GUARD  = ACC_GUARD_DEF,
    localparam int CNT_W      = $clog2(MAX_INPUTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_inputs,
    input  feature_t         bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  feature_t         in_feature,
    input  weight_t          in_weight,
    output logic             out_valid,
    input  logic             out_ready,
    output feature_t         out_feature,
    output sum_t             out_sum,
    output logic             busy,
    output neuron_state_e    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and out_valid holds until taken.

    // Guard never drops below log2(MAX_INPUTS) so full-scale products cannot wrap.
    localparam int LOG_IN  = $clog2(MAX_INPUTS);
    localparam int GUARD_W = (ACC_GUARD > LOG_IN) ? ACC_GUARD : LOG_IN;
    localparam int NACC_W  = SUM_W + GUARD_W;

    neuron_state_e state_q, state_d;

    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         num_q;
    feature_t                 bias_q;
    sum_t                     prod_q;
    logic                     prod_vld_q;
    logic signed [NACC_W-1:0] acc_q;
    feature_t                 out_feature_q;
    sum_t                     out_sum_q;

    sum_t     prod_d;
    sum_t     relu_sum;
    feature_t relu_feature;
    logic     beat;
    logic     start_take;
    logic     last_beat;

    always_comb begin
        beat       = (state_q == ST_ACCUM) && in_valid;
        start_take = (state_q == ST_IDLE) && start;
        last_beat  = beat && ((cnt_q + CNT_W'(1)) == num_q);
        prod_d     = {{(SUM_W-FEATURE_W){in_feature[FEATURE_W-1]}}, in_feature}
                   * {{(SUM_W-WEIGHT_W){in_weight[WEIGHT_W-1]}}, in_weight};
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_inputs == '0) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            num_q         <= '0;
            bias_q        <= '0;
            prod_q        <= '0;
            prod_vld_q    <= 1'b0;
            acc_q         <= '0;
            out_feature_q <= '0;
            out_sum_q     <= '0;
        end else begin
            prod_vld_q <= beat;
            if (beat) begin
                prod_q <= prod_d;
            end
            if (start_take) begin
                num_q  <= num_inputs;
                bias_q <= bias;
                cnt_q  <= '0;
                acc_q  <= '0;
            end else begin
                if (beat) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (prod_vld_q) begin
                    acc_q <= acc_q + {{(NACC_W-SUM_W){prod_q[SUM_W-1]}}, prod_q};
                end
            end
            if (state_q == ST_FINISH) begin
                out_feature_q <= relu_feature;
                out_sum_q     <= relu_sum;
            end
        end
    end

    mnist_relu_sat #(
        .ACC_W_P (NACC_W)
    ) u_relu_sat (
        .acc_i     (acc_q),
        .bias_i    (bias_q),
        .sum_o     (relu_sum),
        .feature_o (relu_feature)
    );

    assign out_feature = out_feature_q;
    assign out_sum     = out_sum_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mnist_neuron_mac.sv
// Bench for mnist_neuron_mac: directed vector table, full-scale and reset
// sequences, and randomized neurons checked against an arithmetic model.
module tb_mnist_neuron_mac;
    import mnist_neuron_mac_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [9:0]    num_inputs;
    logic [15:0]   bias;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_feature;
    logic [15:0]   in_weight;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_feature;
    logic [31:0]   out_sum;
    logic          busy;
    neuron_state_e dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [15:0] feat_a[784];
    logic [15:0] wgt_a[784];

    typedef struct packed {
        logic [9:0]        n;
        logic [15:0]       b;
        logic [3:0][15:0]  f;
        logic [3:0][15:0]  w;
        logic [31:0]       es;
        logic [15:0]       ef;
    } vec_t;

    vec_t vecs[8];

    mnist_neuron_mac dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_inputs  (num_inputs),
        .bias        (bias),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_feature  (in_feature),
        .in_weight   (in_weight),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_feature (out_feature),
        .out_sum     (out_sum),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer dot product, floor division by 2^8, clamp.
    function automatic void model(input int n, input logic [15:0] b,
                                  output logic [31:0] es, output logic [15:0] ef);
        longint acc;
        longint q;
        longint s;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(feat_a[i])) * longint'($signed(wgt_a[i]));
        end
        q = acc / 256;
        if ((acc % 256) != 0 && acc < 0) q = q - 1;
        s = q + longint'($signed(b));
        if (s > 64'sd2147483647) es = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) es = 32'h8000_0000;
        else es = s[31:0];
        if (s < 0) ef = 16'h0000;
        else if (s > 32767) ef = 16'h7FFF;
        else ef = s[15:0];
    endfunction

    task automatic set_vec(input int i, input int n, input logic [15:0] b,
                           input logic [15:0] f0, input logic [15:0] w0,
                           input logic [15:0] f1, input logic [15:0] w1,
                           input logic [15:0] f2, input logic [15:0] w2,
                           input logic [15:0] f3, input logic [15:0] w3,
                           input logic [31:0] es, input logic [15:0] ef);
        vecs[i].n    = n[9:0];
        vecs[i].b    = b;
        vecs[i].f[0] = f0; vecs[i].w[0] = w0;
        vecs[i].f[1] = f1; vecs[i].w[1] = w1;
        vecs[i].f[2] = f2; vecs[i].w[2] = w2;
        vecs[i].f[3] = f3; vecs[i].w[3] = w3;
        vecs[i].es   = es;
        vecs[i].ef   = ef;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one neuron evaluation; lat = cycles from last accepted beat (or
    // start when n==0) to the first cycle out_valid is seen high.
    task automatic run_neuron(input string tag, input int n, input logic [15:0] b,
                              input logic [31:0] es, input logic [15:0] ef,
                              input int gap_pct, input int stall, input bit noise,
                              output int lat);
        int idx;
        int budget;
        int last_cyc;
        int waited;
        bit seen_ready;
        idx        = 0;
        budget     = n * 20 + 50;
        seen_ready = 1'b0;
        lat        = -1;
        @(negedge clk);
        start      = 1'b1;
        num_inputs = n[9:0];
        bias       = b;
        last_cyc   = cyc;
        @(negedge clk);
        start = noise;
        while (idx < n && budget > 0) begin
            in_valid   = (int'($urandom_range(0, 99)) >= gap_pct);
            in_feature = feat_a[idx];
            in_weight  = wgt_a[idx];
            if (noise) begin
                num_inputs = 10'($urandom);
                bias       = 16'($urandom);
            end
            if (in_ready) seen_ready = 1'b1;
            if (in_valid && in_ready) begin
                idx++;
                last_cyc = cyc;
            end
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        check({tag, " beats accepted"}, 64'(idx), 64'(n));
        waited = 0;
        while (!out_valid && waited < 20) begin
            if (in_ready) seen_ready = 1'b1;
            @(negedge clk);
            waited++;
        end
        lat = cyc - last_cyc;
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        if (!out_valid) begin
            do_reset();
            return;
        end
        check({tag, " out_sum"}, 64'(out_sum), 64'(es));
        check({tag, " out_feature"}, 64'(out_feature), 64'(ef));
        check({tag, " busy"}, 64'(busy), 64'd1);
        if (n == 0) check({tag, " in_ready never high"}, 64'(seen_ready), 64'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold out_sum"}, 64'(out_sum), 64'(es));
            check({tag, " hold out_feature"}, 64'(out_feature), 64'(ef));
        end
        out_ready = 1'b1;
        start     = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
        check({tag, " idle after accept"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] es;
        logic [15:0] ef;
        logic [15:0] b;
        int n;

        rst_n = 1'b0; start = 1'b0; num_inputs = '0; bias = '0;
        in_valid = 1'b0; in_feature = '0; in_weight = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_feature", 64'(out_feature), 64'd0);
        check("reset out_sum", 64'(out_sum), 64'd0);
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        set_vec(0, 1, 16'h0000, 16'h0100, 16'h0200, 0, 0, 0, 0, 0, 0, 32'h0000_0200, 16'h0200);
        set_vec(1, 3, 16'h0080, 16'h0100, 16'h0100, 16'h0200, 16'hFF80, 16'h0080, 16'h0080, 0, 0,
                32'h0000_00C0, 16'h00C0);
        set_vec(2, 2, 16'h0000, 16'h0100, 16'hFD00, 16'h0100, 16'h0100, 0, 0, 0, 0,
                32'hFFFF_FE00, 16'h0000);
        set_vec(3, 0, 16'h0300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300, 16'h0300);
        set_vec(4, 1, 16'h0000, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 16'h0000);
        set_vec(5, 1, 16'h0001, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 16'h0000);
        set_vec(6, 2, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0,
                32'h007F_FE00, 16'h7FFF);
        set_vec(7, 4, 16'hFF00, 16'h0180, 16'h0100, 16'h0040, 16'hFFC0, 16'h0100, 16'h0100,
                16'hFF00, 16'h0080, 32'h0000_00F0, 16'h00F0);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                feat_a[j] = vecs[i].f[j];
                wgt_a[j]  = vecs[i].w[j];
            end
            run_neuron($sformatf("vec%0d", i), int'(vecs[i].n), vecs[i].b,
                       vecs[i].es, vecs[i].ef, 0, 1, 1'b0, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
        end

        for (int j = 0; j < 784; j++) begin
            feat_a[j] = 16'h7FFF;
            wgt_a[j]  = 16'h7FFF;
        end
        run_neuron("full_pos", 784, 16'h0000, 32'h7FFF_FFFF, 16'h7FFF, 30, 5, 1'b1, lat);
        check("full_pos latency", 64'(lat), 64'd3);

        for (int j = 0; j < 784; j++) begin
            feat_a[j] = 16'h8000;
            wgt_a[j]  = 16'h7FFF;
        end
        run_neuron("full_neg", 784, 16'h0000, 32'h8000_0000, 16'h0000, 0, 0, 1'b0, lat);
        check("full_neg latency", 64'(lat), 64'd3);

        @(negedge clk);
        start = 1'b1; num_inputs = 10'd4; bias = 16'h0055;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_feature = 16'h0100; in_weight = 16'h0300;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd0);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst out_feature", 64'(out_feature), 64'd0);
        check("midrst out_sum", 64'(out_sum), 64'd0);
        check("midrst state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        feat_a[0] = 16'h0100;
        wgt_a[0]  = 16'h0100;
        run_neuron("after_rst", 1, 16'h0000, 32'h0000_0100, 16'h0100, 0, 2, 1'b0, lat);
        check("after_rst latency", 64'(lat), 64'd3);

        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(1, 40));
            for (int j = 0; j < n; j++) begin
                if (i % 2 == 0) begin
                    feat_a[j] = 16'($urandom_range(0, 1023)) - 16'd512;
                    wgt_a[j]  = 16'($urandom_range(0, 1023)) - 16'd512;
                end else begin
                    feat_a[j] = 16'($urandom);
                    wgt_a[j]  = 16'($urandom);
                end
            end
            b = (i % 2 == 0) ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom);
            model(n, b, es, ef);
            run_neuron($sformatf("rand%0d", i), n, b, es, ef, 25,
                       int'($urandom_range(0, 3)), (i % 3 == 0), lat);
            check($sformatf("rand%0d latency", i), 64'(lat), 64'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
